// File: rtl/fft_twiddle_regread.sv
// fft_twiddle_regread: registered twiddle lookup and operand fetch stage for a 64-point radix-2 FFT
module fft_twiddle_regread #(
  parameter int D_WIDTH    = 64,
  parameter int LOG2_WIDTH = 6,
  parameter int DATA_W     = 16,
  parameter int TW_W       = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [LOG2_WIDTH-1:0]       tw_index,
  input  logic [LOG2_WIDTH-1:0]       idx_a,
  input  logic [LOG2_WIDTH-1:0]       idx_b,
  input  logic [D_WIDTH*DATA_W-1:0]   regs_flat,
  output logic [TW_W-1:0]             tw_re,
  output logic [TW_W-1:0]             tw_im,
  output logic [DATA_W-1:0]           data_a,
  output logic [DATA_W-1:0]           data_b,
  output logic                        out_valid
);
  // quarter-wave magnitudes round(256*sin(2*pi*q/64)), q = 0..16
  localparam logic [TW_W-1:0] S [17] = '{
    9'd0,   9'd25,  9'd50,  9'd74,  9'd98,  9'd121, 9'd142, 9'd162, 9'd181,
    9'd198, 9'd213, 9'd226, 9'd237, 9'd245, 9'd251, 9'd255, 9'd256
  };
  // -sin table built from the quarter wave; +256 at index 48 clips to 255
  function automatic logic [TW_W-1:0] tbl(input logic [LOG2_WIDTH-1:0] j);
    logic [4:0] q;
    logic [TW_W-1:0] m;
    q = j[4] ? 5'd16 - {1'b0, j[3:0]} : {1'b0, j[3:0]};
    m = S[q];
    return j[5] ? (m[8] ? 9'd255 : m) : 9'd0 - m;
  endfunction
  logic [TW_W-1:0]   re_q, re_d, im_q, im_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              valid_q, valid_d;
  logic [LOG2_WIDTH-1:0] re_idx;
  assign re_idx = tw_index + 6'd48;
  // next-state: capture fresh lookups when enabled, otherwise hold
  always_comb begin
    re_d    = en ? tbl(re_idx) : re_q;
    im_d    = en ? tbl(tw_index) : im_q;
    a_d     = en ? regs_flat[DATA_W*idx_a +: DATA_W] : a_q;
    b_d     = en ? regs_flat[DATA_W*idx_b +: DATA_W] : b_q;
    valid_d = en;
  end
  // output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_q    <= '0;
      im_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      re_q    <= re_d;
      im_q    <= im_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end
  assign tw_re     = re_q;
  assign tw_im     = im_q;
  assign data_a    = a_q;
  assign data_b    = b_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_fft_twiddle_regread.sv
// tb_fft_twiddle_regread: vector table, full sweep, hold, async reset and random checks against a real-valued model
module tb_fft_twiddle_regread;
  logic          clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [5:0]    tw_index = '0, idx_a = '0, idx_b = '0;
  logic [1023:0] regs_flat = '0;
  logic [8:0]    tw_re, tw_im;
  logic [15:0]   data_a, data_b;
  logic          out_valid;
  int            errors = 0, checks = 0;
  logic [15:0]   w [64];

  typedef struct {
    logic [5:0]  tw, a, b;
    int          re, im;
    logic [15:0] da, db;
  } vec_t;
  vec_t vecs [6];

  fft_twiddle_regread dut (
    .clk(clk), .rst(rst), .en(en), .tw_index(tw_index), .idx_a(idx_a), .idx_b(idx_b),
    .regs_flat(regs_flat), .tw_re(tw_re), .tw_im(tw_im), .data_a(data_a), .data_b(data_b),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int tw_model(input int j);
    real v;
    int r;
    v = -256.0 * $sin(2.0 * 3.14159265358979 * j / 64.0);
    r = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
    return (r > 255) ? 255 : ((r < -256) ? -256 : r);
  endfunction

  task automatic pack();
    for (int i = 0; i < 64; i++) regs_flat[16*i +: 16] = w[i];
  endtask

  task automatic drive(input logic e, input logic [5:0] t, input logic [5:0] a, input logic [5:0] b);
    en = e; tw_index = t; idx_a = a; idx_b = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string n, input int re, input int im, input int a, input int b, input int v);
    check({n, ".tw_re"}, int'($signed(tw_re)), re);
    check({n, ".tw_im"}, int'($signed(tw_im)), im);
    check({n, ".data_a"}, int'(data_a), a);
    check({n, ".data_b"}, int'(data_b), b);
    check({n, ".valid"}, int'(out_valid), v);
  endtask

  initial begin
    int m_re, m_im, m_a, m_b, m_v;
    logic e;
    logic [5:0] t, a, b;
    vecs[0] = '{6'd8,  6'd0,  6'd63, 181,  -181, 16'hA000, 16'hA03F};
    vecs[1] = '{6'd16, 6'd37, 6'd37, 0,    -256, 16'hA025, 16'hA025};
    vecs[2] = '{6'd32, 6'd5,  6'd10, -256, 0,    16'hA005, 16'hA00A};
    vecs[3] = '{6'd4,  6'd63, 6'd0,  237,  -98,  16'hA03F, 16'hA000};
    vecs[4] = '{6'd60, 6'd1,  6'd2,  237,  98,   16'hA001, 16'hA002};
    vecs[5] = '{6'd20, 6'd20, 6'd44, -98,  -237, 16'hA014, 16'hA02C};

    // held in reset with activity on the inputs
    for (int i = 0; i < 64; i++) w[i] = 16'($urandom);
    pack();
    for (int i = 0; i < 4; i++) drive(1'b1, 6'($urandom), 6'($urandom), 6'($urandom));
    check_out("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 64; i++) w[i] = 16'hA000 + 16'(i);
    pack();
    rst = 1'b1;
    drive(1'b1, 6'd0, 6'd0, 6'd63);
    check_out("release", 255, 0, 'hA000, 'hA03F, 1);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].tw, vecs[i].a, vecs[i].b);
      check_out($sformatf("vec%0d", i), vecs[i].re, vecs[i].im, int'(vecs[i].da), int'(vecs[i].db), 1);
    end

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'(i), 6'(i), 6'(63 - i));
      check_out($sformatf("sweep%0d", i), tw_model((i + 48) % 64), tw_model(i), int'(w[i]), int'(w[63 - i]), 1);
    end

    // hold: outputs frozen while en is low and inputs churn
    drive(1'b1, 6'd8, 6'd1, 6'd2);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 64; k++) w[k] = 16'($urandom);
      pack();
      drive(1'b0, 6'($urandom), 6'($urandom), 6'($urandom));
      check_out($sformatf("hold%0d", i), 181, -181, 'hA001, 'hA002, 0);
    end
    drive(1'b1, 6'd32, 6'd7, 6'd9);
    check_out("resume", -256, 0, int'(w[7]), int'(w[9]), 1);

    // asynchronous clear between clock edges
    drive(1'b1, 6'd4, 6'd3, 6'd4);
    #2 rst = 1'b0;
    #1 check_out("async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 6'd4, 6'd3, 6'd4);
    check_out("post_async_idle", 0, 0, 0, 0, 0);
    drive(1'b1, 6'd20, 6'd3, 6'd4);
    check_out("post_async", -98, -237, int'(w[3]), int'(w[4]), 1);

    // random stream against the model
    m_re = -98; m_im = -237; m_a = int'(w[3]); m_b = int'(w[4]);
    for (int i = 0; i < 300; i++) begin
      e = 1'($urandom);
      t = 6'($urandom); a = 6'($urandom); b = (i % 7 == 0) ? a : 6'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        w[$urandom_range(0, 63)] = 16'($urandom);
        pack();
      end
      if (e) begin
        m_re = tw_model((int'(t) + 48) % 64);
        m_im = tw_model(int'(t));
        m_a = int'(w[a]);
        m_b = int'(w[b]);
      end
      m_v = int'(e);
      drive(e, t, a, b);
      check_out($sformatf("rand%0d", i), m_re, m_im, m_a, m_b, m_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
